// File: rtl/subroutine_stack_ctrl.sv
// subroutine_stack_ctrl: LIFO return-address controller for the subroutine
// mechanism. A CALL pushes dataIn (pc+2), a RET pops the top entry onto dataOut
// and pulses retValid for one cycle. Pushing when full or popping when empty
// parks the block in a terminal FAULT state with a sticky flag.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   call      in   push request (sampled only when idle)
//   ret       in   pop request (sampled only when idle, wins over call)
//   dataIn    in   return address to push
//   dataOut   out  most recently popped return address
//   retValid  out  one-cycle strobe, dataOut is freshly popped
//   busy      out  high whenever the controller is not idle
//   depth     out  number of valid entries
//   overflow  out  sticky, call issued while full
//   underflow out  sticky, ret issued while empty
module subroutine_stack_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] dataIn,
  output logic [AW-1:0] dataOut,
  output logic          retValid,
  output logic          busy,
  output logic [CW-1:0] depth,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   hold_q, hold_d;
  logic [AW-1:0]   data_q, data_d;
  logic [CW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            busy_q;
  logic            rv_q;
  logic [AW-1:0]   entry_q [DEPTH];

  logic            empty;
  logic            full;
  logic [IW-1:0]   push_idx;
  logic [IW-1:0]   pop_idx;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == CW'(DEPTH));
  assign push_idx = IW'(depth_q);
  assign pop_idx  = IW'(depth_q - CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ret has priority over call in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ret) begin
          state_d = empty ? FAULT : POP;
        end else if (call) begin
          state_d = full ? FAULT : PUSH;
        end
      end
      PUSH:    state_d = IDLE;
      POP:     state_d = DONE;
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values, driven by the current state
  always_comb begin
    hold_d  = hold_q;
    data_d  = data_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (ret) begin
          if (empty) unf_d = 1'b1;
        end else if (call) begin
          if (full) ovf_d = 1'b1;
          else      hold_d = dataIn;
        end
      end
      PUSH: depth_d = depth_q + CW'(1);
      POP: begin
        data_d  = entry_q[pop_idx];
        depth_d = depth_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Datapath and registered status outputs; busy/retValid follow the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      data_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      data_q  <= data_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      busy_q  <= (state_d != IDLE);
      rv_q    <= (state_d == DONE);
    end
  end

  // Entry storage is not reset: an entry is unreadable until rewritten
  always_ff @(posedge clk) begin
    if (!reset && state_q == PUSH) begin
      entry_q[push_idx] <= hold_q;
    end
  end

  assign dataOut   = data_q;
  assign retValid  = rv_q;
  assign busy      = busy_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_subroutine_stack_ctrl.sv
// Testbench for subroutine_stack_ctrl: directed call/ret sequences; popped
// addresses are queued as expected and matched by a monitor on retValid.
module tb_subroutine_stack_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [AW-1:0] dataIn = '0;
  logic [AW-1:0] dataOut;
  logic          retValid;
  logic          busy;
  logic [CW-1:0] depth;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q [$];

  subroutine_stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .call     (call),
    .ret      (ret),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .retValid (retValid),
    .busy     (busy),
    .depth    (depth),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_call(input logic [AW-1:0] a, input int d_after);
    call   = 1'b1;
    dataIn = a;
    tick();
    call = 1'b0;
    chk("call_busy", 32'(busy), 1);
    chk("call_depth_pending", 32'(depth), 32'(d_after - 1));
    tick();
    chk("call_idle", 32'(busy), 0);
    chk("call_depth", 32'(depth), 32'(d_after));
  endtask

  task automatic do_ret(input logic [AW-1:0] e, input int d_after);
    exp_q.push_back(e);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("ret_busy", 32'(busy), 1);
    chk("ret_no_early_valid", 32'(retValid), 0);
    tick();
    chk("ret_valid", 32'(retValid), 1);
    chk("ret_data", 32'(dataOut), 32'(e));
    chk("ret_depth", 32'(depth), 32'(d_after));
    tick();
    chk("ret_idle", 32'(busy), 0);
    chk("ret_valid_clear", 32'(retValid), 0);
  endtask

  // Monitor: every retValid pulse must match the oldest expected pop
  always @(negedge clk) begin
    if (retValid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_retValid: dataOut 0x%0h, expected no pulse at %0t", dataOut, $time);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (dataOut !== e) begin
          errors++;
          $display("FAIL pop_order: got 0x%0h, expected 0x%0h at %0t", dataOut, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_dataOut", 32'(dataOut), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_retValid", 32'(retValid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);

    // Single round trip
    do_call(8'h12, 1);
    do_ret(8'h12, 0);

    // LIFO nesting
    do_call(8'h10, 1);
    do_call(8'h20, 2);
    do_call(8'h30, 3);
    do_call(8'h40, 4);
    chk("nest_depth", 32'(depth), 4);
    do_ret(8'h40, 3);
    do_ret(8'h30, 2);
    do_ret(8'h20, 1);
    do_ret(8'h10, 0);

    // Call held through PUSH is ignored the second time
    call   = 1'b1;
    dataIn = 8'h55;
    tick();
    dataIn = 8'h99;
    chk("cont_busy", 32'(busy), 1);
    tick();
    call = 1'b0;
    chk("cont_depth", 32'(depth), 1);
    tick();
    chk("cont_depth_hold", 32'(depth), 1);

    // call and ret together: ret wins, no push
    exp_q.push_back(8'h55);
    call   = 1'b1;
    ret    = 1'b1;
    dataIn = 8'hAA;
    tick();
    call = 1'b0;
    ret  = 1'b0;
    chk("both_busy", 32'(busy), 1);
    tick();
    chk("both_valid", 32'(retValid), 1);
    chk("both_data", 32'(dataOut), 32'h55);
    chk("both_depth", 32'(depth), 0);
    tick();
    tick();
    chk("both_no_push", 32'(depth), 0);
    chk("both_idle", 32'(busy), 0);

    // Overflow on fifth call
    do_call(8'h01, 1);
    do_call(8'h02, 2);
    do_call(8'h03, 3);
    do_call(8'h04, 4);
    call   = 1'b1;
    dataIn = 8'hEE;
    tick();
    call = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_busy", 32'(busy), 1);
    chk("ovf_depth", 32'(depth), 4);
    chk("ovf_no_underflow", 32'(underflow), 0);
    ret = 1'b1;
    repeat (3) tick();
    ret = 1'b0;
    tick();
    chk("fault_depth_frozen", 32'(depth), 4);
    chk("fault_busy_stuck", 32'(busy), 1);
    chk("fault_dataOut_frozen", 32'(dataOut), 32'h55);
    chk("fault_ovf_sticky", 32'(overflow), 1);

    // Underflow on ret when empty
    do_reset();
    chk("rst2_overflow", 32'(overflow), 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_dataOut", 32'(dataOut), 0);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_busy", 32'(busy), 1);
    chk("unf_depth", 32'(depth), 0);
    repeat (3) tick();
    chk("unf_no_valid", 32'(retValid), 0);
    chk("unf_sticky", 32'(underflow), 1);
    chk("unf_no_overflow", 32'(overflow), 0);

    // Reset during POP aborts the pop
    do_reset();
    do_call(8'h33, 1);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("abort_in_pop", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_depth", 32'(depth), 0);
    chk("abort_dataOut", 32'(dataOut), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(retValid), 0);
    repeat (3) tick();
    chk("abort_depth_later", 32'(depth), 0);
    chk("abort_dataOut_later", 32'(dataOut), 0);
    chk("abort_idle_later", 32'(busy), 0);

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
